pc_16bit_chip: RTL

- Hack-style program counter.
- Consumes the 16-bit jump target selected by the upstream 16-bit mux (A-register value) and evaluates the ALU jump condition.
- Its registered output addresses instruction ROM.
- Adds halt detection for the canonical end-of-program loop, so benches and top-level sims can stop cleanly.

---
 rtl/chips_pkg.sv | 16 +
 rtl/jump_cond_chip.sv | 17 +
 rtl/pc_16bit_chip.sv | 97 +++++++++
 3 files changed

// File: rtl/chips_pkg.sv
// rtl/chips_pkg.sv - shared types and constants for the Hack-style PC chips
package chips_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_e;

  // Bit positions inside jbits = {j1, j2, j3}
  localparam int unsigned J_NG  = 2;
  localparam int unsigned J_ZR  = 1;
  localparam int unsigned J_POS = 0;

  localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/jump_cond_chip.sv
// rtl/jump_cond_chip.sv - combinational Hack jump-condition evaluator
module jump_cond_chip
  import chips_pkg::*;
(
  input  logic [2:0] jbits,
  input  logic       zr,
  input  logic       ng,
  input  logic       jmp_en,
  output logic       cond
);

  // zr=ng=1 cannot come from the ALU but is evaluated literally anyway
  assign cond = jmp_en & ((jbits[J_NG]  & ng) |
                          (jbits[J_ZR]  & zr) |
                          (jbits[J_POS] & ~ng & ~zr));

endmodule

// File: rtl/pc_16bit_chip.sv
// rtl/pc_16bit_chip.sv - program counter with conditional jump, RUN-cycle counter and end-loop halt detection
module pc_16bit_chip
  import chips_pkg::*;
#(
  parameter int                WIDTH        = 16,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int                HALT_DETECT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             clear,
  input  logic             jmp_en,
  input  logic [2:0]       jbits,
  input  logic             zr,
  input  logic             ng,
  output logic [WIDTH-1:0] out,
  output logic             jumped,
  output logic             halted,
  output logic [WIDTH-1:0] cycles
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic             jumped_q, jumped_d;
  pc_state_e        state_q, state_d;
  logic             cond;
  logic             ld;
  logic             end_loop;

  jump_cond_chip u_jump_cond (
    .jbits  (jbits),
    .zr     (zr),
    .ng     (ng),
    .jmp_en (jmp_en),
    .cond   (cond)
  );

  assign ld = load | cond;

  // "@END; 0;JMP" targets itself, "(END) 0;JMP" targets the previous word
  assign end_loop = (in == pc_q) || (in == (pc_q - WIDTH'(1)));

  always_comb begin
    pc_d     = pc_q;
    cyc_d    = cyc_q;
    state_d  = state_q;
    jumped_d = 1'b0;
    if (state_q == HALT) begin
      if (clear) begin
        pc_d    = RESET_VECTOR;
        cyc_d   = '0;
        state_d = RUN;
      end
    end else begin
      jumped_d = cond & ~clear;
      if (clear) begin
        pc_d  = RESET_VECTOR;
        cyc_d = '0;
      end else begin
        if (ld) begin
          pc_d = in;
        end else if (inc) begin
          pc_d = pc_q + WIDTH'(1);
        end
        if (cyc_q != {WIDTH{1'b1}}) begin
          cyc_d = cyc_q + WIDTH'(1);
        end
        if ((HALT_DETECT != 0) && cond && end_loop) begin
          state_d = HALT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      cyc_q    <= '0;
      jumped_q <= 1'b0;
      state_q  <= RUN;
    end else begin
      pc_q     <= pc_d;
      cyc_q    <= cyc_d;
      jumped_q <= jumped_d;
      state_q  <= state_d;
    end
  end

  assign out    = pc_q;
  assign cycles = cyc_q;
  assign jumped = jumped_q;
  assign halted = (state_q == HALT);

endmodule
